// File: rtl/scan_seq_139.sv
// -----------------------------------------------------------------------------
// scan_seq_139
// Digit-scan sequencer for a 74x139-style 2-to-4 active-low decoder.
// Steps round-robin through four slots and skips slots whose MASK bit is
// clear. Each slot is a blanking interval (decoder disabled) followed by a
// drive interval. A/B therefore only move while G_L is high.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   EN         run enable, 0 forces idle
//   MASK[3:0]  slot enable, bit i = 1 scans slot i
//   G_L        decoder enable, active low (registered)
//   A, B       decoder selects, slot index LSB/MSB (registered)
//   SLOT_TICK  one-cycle pulse on each DRIVE->BLANK advance (registered)
//   ACTIVE     high while in BLANK or DRIVE (registered)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | stopped, decoder disabled, waiting for EN=1 and MASK!=0
// ST_BLANK | slot select settled, decoder disabled for BLANK cycles
// ST_DRIVE | decoder enabled until the slot's DIV cycles are used up
// -----------------------------------------------------------------------------
module scan_seq_139 #(
  parameter int CW    = 8,
  parameter int DIV   = 16,
  parameter int BLANK = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [3:0] MASK,
  output logic       G_L,
  output logic       A,
  output logic       B,
  output logic       SLOT_TICK,
  output logic       ACTIVE
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [CW-1:0] C_BLANK_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] C_SLOT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  logic [1:0]    r_state;
  logic [1:0]    r_s;
  logic [CW-1:0] r_c;
  logic          r_gl;
  logic          r_tick;
  logic          r_active;

  logic [1:0]    w_state_nxt;
  logic [1:0]    w_s_nxt;
  logic [CW-1:0] w_c_nxt;
  logic          w_gl_nxt;
  logic          w_tick_nxt;
  logic [1:0]    w_first;
  logic [1:0]    w_next;
  logic          w_slot_on;

  assign w_slot_on = MASK[r_s];

  // Lowest set bit of MASK; iterating downward lets the lowest index win.
  always_comb begin
    w_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (MASK[i]) w_first = 2'(i);
    end
  end

  // Next set bit searched cyclically from r_s+1. Offset 4 wraps back onto
  // r_s itself, covering the single-slot case; nearest offset wins.
  always_comb begin
    w_next = r_s;
    for (int i = 4; i >= 1; i--) begin
      if (MASK[r_s + 2'(i)]) w_next = r_s + 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_c_nxt     = r_c;
    w_gl_nxt    = r_gl;
    w_tick_nxt  = 1'b0;
    if (!EN) begin
      w_state_nxt = ST_IDLE;
      w_c_nxt     = '0;
      w_gl_nxt    = 1'b1;
    end else if (r_state != ST_IDLE && MASK == 4'd0) begin
      // S and C are left alone; a restart reloads both.
      w_state_nxt = ST_IDLE;
      w_gl_nxt    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MASK != 4'd0) begin
            w_state_nxt = ST_BLANK;
            w_s_nxt     = w_first;
            w_c_nxt     = '0;
            w_gl_nxt    = 1'b1;
          end
        end
        ST_BLANK: begin
          w_c_nxt = r_c + C_ONE;
          if (r_c == C_BLANK_END) begin
            w_state_nxt = ST_DRIVE;
            // A slot masked off during blanking never lights up.
            w_gl_nxt    = ~w_slot_on;
          end
        end
        ST_DRIVE: begin
          if (r_c == C_SLOT_END) begin
            w_state_nxt = ST_BLANK;
            w_c_nxt     = '0;
            w_s_nxt     = w_next;
            w_gl_nxt    = 1'b1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_c_nxt  = r_c + C_ONE;
            // Once darkened by a mid-slot mask clear, stay dark to slot end.
            w_gl_nxt = r_gl | ~w_slot_on;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_gl_nxt    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_s      <= 2'd0;
      r_c      <= '0;
      r_gl     <= 1'b1;
      r_tick   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_c      <= w_c_nxt;
      r_gl     <= w_gl_nxt;
      r_tick   <= w_tick_nxt;
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  assign G_L       = r_gl;
  assign A         = r_s[0];
  assign B         = r_s[1];
  assign SLOT_TICK = r_tick;
  assign ACTIVE    = r_active;

endmodule

// File: tb/tb_scan_seq_139.sv
// -----------------------------------------------------------------------------
// tb_scan_seq_139
// Self-checking bench for scan_seq_139 (DIV=8, BLANK=2): a fixed vector table,
// hand-written corner sequences and a randomized run, all compared against a
// slot-position model of the scan behaviour.
// -----------------------------------------------------------------------------
module tb_scan_seq_139;

  localparam int CW    = 8;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] MASK = 4'h0;
  logic       G_L, A, B, SLOT_TICK, ACTIVE;

  int checks = 0;
  int failures = 0;

  scan_seq_139 #(.CW(CW), .DIV(DIV), .BLANK(BLANK)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MASK(MASK),
    .G_L(G_L), .A(A), .B(B), .SLOT_TICK(SLOT_TICK), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  // model: running flag, slot, position within the slot, darkened flag
  bit m_run = 0;
  bit m_kill = 0;
  bit m_tick = 0;
  int m_slot = 0;
  int m_pos = 0;
  logic [1:0] prev_ab;

  typedef struct {
    bit rst; bit en; logic [3:0] mask;
    bit gl; bit a; bit b; bit tick; bit act;
  } vec_t;
  vec_t tbl[18];

  function automatic int lowest_set(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_set(input int s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(s + k) % 4]) return (s + k) % 4;
    return s;
  endfunction

  task automatic model_step(input bit rst, input bit en, input logic [3:0] m);
    m_tick = 0;
    if (rst) begin
      m_run = 0; m_slot = 0; m_pos = 0; m_kill = 0;
    end else if (!en) begin
      m_run = 0; m_pos = 0;
    end else if (m_run && m == 4'd0) begin
      m_run = 0;
    end else if (!m_run) begin
      if (m != 4'd0) begin
        m_run = 1; m_slot = lowest_set(m); m_pos = 0; m_kill = 0;
      end
    end else if (m_pos == DIV - 1) begin
      m_pos = 0; m_slot = next_set(m_slot, m); m_tick = 1; m_kill = 0;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos >= BLANK && !m[m_slot]) m_kill = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_step(input bit rst, input bit en, input logic [3:0] m);
    prev_ab = {B, A};
    RESET = rst; EN = en; MASK = m;
    @(posedge CLK);
    model_step(rst, en, m);
    #1;
    if (G_L === 1'b0) chk("ab_stable_while_driven", {6'd0, B, A}, {6'd0, prev_ab});
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [3:0] m);
    drive_step(rst, en, m);
    chk("model_G_L", {7'd0, G_L}, (m_run && m_pos >= BLANK && !m_kill) ? 8'd0 : 8'd1);
    chk("model_AB", {6'd0, B, A}, 8'(m_slot));
    chk("model_SLOT_TICK", {7'd0, SLOT_TICK}, {7'd0, m_tick});
    chk("model_ACTIVE", {7'd0, ACTIVE}, {7'd0, m_run});
  endtask

  initial begin
    int ticks, glhi, bad;
    logic [1:0] seq[$];
    logic [1:0] exp_seq[4];

    // reset x3, start with all slots, first advance, EN drop in DRIVE, restart
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 18; i++) begin
      drive_step(tbl[i].rst, tbl[i].en, tbl[i].mask);
      chk($sformatf("tbl%0d_G_L", i), {7'd0, G_L}, {7'd0, tbl[i].gl});
      chk($sformatf("tbl%0d_A", i), {7'd0, A}, {7'd0, tbl[i].a});
      chk($sformatf("tbl%0d_B", i), {7'd0, B}, {7'd0, tbl[i].b});
      chk($sformatf("tbl%0d_TICK", i), {7'd0, SLOT_TICK}, {7'd0, tbl[i].tick});
      chk($sformatf("tbl%0d_ACTIVE", i), {7'd0, ACTIVE}, {7'd0, tbl[i].act});
    end

    // full scan: slot order at each tick is 1,2,3,0
    cyc(1, 0, 4'hF);
    ticks = 0; seq.delete();
    for (int j = 0; j < 40; j++) begin
      cyc(0, 1, 4'hF);
      if (SLOT_TICK === 1'b1) begin ticks++; seq.push_back({B, A}); end
    end
    chk("full_scan_ticks", 8'(ticks), 8'd4);
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++)
      chk($sformatf("full_scan_slot%0d", k), (k < seq.size()) ? {6'd0, seq[k]} : 8'hFF, {6'd0, exp_seq[k]});

    // skip mask 1010: first slot 1, then 3, 1; slots 0 and 2 never appear
    cyc(1, 0, 4'hA);
    bad = 0; seq.delete();
    for (int j = 0; j < 24; j++) begin
      cyc(0, 1, 4'hA);
      if (j == 0) chk("skip_first_slot", {6'd0, B, A}, 8'd1);
      if (A !== 1'b1) bad++;
      if (SLOT_TICK === 1'b1) seq.push_back({B, A});
    end
    chk("skip_even_slots_seen", 8'(bad), 8'd0);
    chk("skip_tick_count", 8'(seq.size()), 8'd2);
    if (seq.size() == 2) begin
      chk("skip_seq0", {6'd0, seq[0]}, 8'd3);
      chk("skip_seq1", {6'd0, seq[1]}, 8'd1);
    end

    // single slot 0100: S stays 2, 2-cycle blank every 8 cycles
    cyc(1, 0, 4'h4);
    ticks = 0; glhi = 0; bad = 0;
    for (int j = 0; j < 24; j++) begin
      cyc(0, 1, 4'h4);
      if ({B, A} !== 2'd2) bad++;
      if (G_L === 1'b1) glhi++;
      if (SLOT_TICK === 1'b1) ticks++;
    end
    chk("single_slot_ab", 8'(bad), 8'd0);
    chk("single_slot_blank_cycles", 8'(glhi), 8'd6);
    chk("single_slot_ticks", 8'(ticks), 8'd2);

    // mid-slot mask clear 3 cycles into DRIVE, then full mask clear
    cyc(1, 0, 4'hF);
    for (int j = 0; j < 5; j++) cyc(0, 1, 4'hF);
    chk("mid_pre_G_L", {7'd0, G_L}, 8'd0);
    cyc(0, 1, 4'hE);
    chk("mid_clear_G_L", {7'd0, G_L}, 8'd1);
    cyc(0, 1, 4'hE);
    chk("mid_c6_tick", {7'd0, SLOT_TICK}, 8'd0);
    cyc(0, 1, 4'hE);
    chk("mid_c7_tick", {7'd0, SLOT_TICK}, 8'd0);
    chk("mid_c7_G_L", {7'd0, G_L}, 8'd1);
    cyc(0, 1, 4'hE);
    chk("mid_end_tick", {7'd0, SLOT_TICK}, 8'd1);
    chk("mid_next_slot", {6'd0, B, A}, 8'd1);
    cyc(0, 1, 4'h0);
    chk("mask0_ACTIVE", {7'd0, ACTIVE}, 8'd0);
    chk("mask0_G_L", {7'd0, G_L}, 8'd1);
    chk("mask0_S_held", {6'd0, B, A}, 8'd1);

    // EN drop during DRIVE and restart
    for (int j = 0; j < 5; j++) cyc(0, 1, 4'hC);
    chk("endrop_pre_G_L", {7'd0, G_L}, 8'd0);
    cyc(0, 0, 4'hC);
    chk("endrop_G_L", {7'd0, G_L}, 8'd1);
    chk("endrop_ACTIVE", {7'd0, ACTIVE}, 8'd0);
    cyc(0, 0, 4'hC);
    cyc(0, 1, 4'hC);
    chk("restart_ACTIVE", {7'd0, ACTIVE}, 8'd1);
    chk("restart_slot", {6'd0, B, A}, 8'd2);
    cyc(0, 1, 4'hC);
    chk("restart_blank2", {7'd0, G_L}, 8'd1);
    cyc(0, 1, 4'hC);
    chk("restart_drive", {7'd0, G_L}, 8'd0);

    // randomized run against the model
    begin
      bit r_en = 1;
      logic [3:0] r_m = 4'hF;
      cyc(1, 0, 4'hF);
      for (int j = 0; j < 3000; j++) begin
        int r;
        bit rs;
        r = $urandom_range(0, 99);
        rs = (r == 0);
        if ($urandom_range(0, 99) < 3) r_en = ~r_en;
        if ($urandom_range(0, 99) < 5) r_m = 4'($urandom_range(0, 15));
        cyc(rs, r_en, r_m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
